// File: rtl/phivers_input_buffer.sv
// ---------------------------------------------------------------------------
// phivers_input_buffer
//
// Input-port buffer for a router. Flits arriving over an inter-router link
// are stored in a circular FIFO, and the oldest one is presented
// first-word-fall-through to the switch / routing stage. The buffer returns a
// credit to the link while it still has space. It also tracks packet
// boundaries through the EOP bit so it can report whether the oldest flit
// starts a packet and how many complete packets it currently holds.
//
// Ports:
//   clk_i       clock, all state updates on the rising edge
//   rst_i       asynchronous active-high reset
//   rx_i        flit valid from the link
//   credit_o    buffer has space (credit return to the link)
//   eop_i       incoming flit is the last of its packet
//   data_i      incoming flit
//   tx_o        buffer non-empty, oldest flit valid on data_o
//   ack_i       switch consumes the oldest flit this cycle
//   eop_o       EOP bit of the oldest flit
//   data_o      oldest flit (zero when empty)
//   head_o      oldest flit is the first flit of a packet
//   pkt_cnt_o   number of complete packets held
//   overflow_o  sticky: a flit arrived while no credit was available
// ---------------------------------------------------------------------------
module phivers_input_buffer #(
    parameter int BUFFER_SIZE = 8,
    parameter int FLIT_SIZE   = 32,
    localparam int CNT_W      = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic                 credit_o,
    input  logic                 eop_i,
    input  logic [FLIT_SIZE-1:0] data_i,
    output logic                 tx_o,
    input  logic                 ack_i,
    output logic                 eop_o,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic                 head_o,
    output logic [CNT_W-1:0]     pkt_cnt_o,
    output logic                 overflow_o
);

    localparam int               PTR_W      = $clog2(BUFFER_SIZE);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(BUFFER_SIZE);

    // Each entry holds {eop, data}.
    logic [FLIT_SIZE:0]   mem_q [BUFFER_SIZE];

    logic [PTR_W-1:0]     wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]     rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]     occupancy_q, occupancy_d;
    logic [CNT_W-1:0]     pktCnt_q, pktCnt_d;
    logic                 atHead_q, atHead_d;
    logic                 overflow_q, overflow_d;

    logic                 txValid;
    logic                 push;
    logic                 pop;
    logic                 pushEop;
    logic                 popEop;
    logic [FLIT_SIZE:0]   oldestEntry;

    // Credit and valid come only from registered occupancy, so the link
    // never sees a combinational path from rx_i or ack_i back to credit_o.
    // A slot freed by a pop is therefore advertised one cycle later.
    assign txValid     = (occupancy_q != '0);
    assign credit_o    = (occupancy_q != FULL_COUNT);
    assign oldestEntry = mem_q[rdPtr_q];

    assign push    = rx_i & credit_o;
    assign pop     = txValid & ack_i;
    assign pushEop = push & eop_i;
    assign popEop  = pop & oldestEntry[FLIT_SIZE];

    // Outputs are forced to zero while empty so stale memory never leaks out.
    assign tx_o       = txValid;
    assign data_o     = txValid ? oldestEntry[FLIT_SIZE-1:0] : '0;
    assign eop_o      = txValid & oldestEntry[FLIT_SIZE];
    assign head_o     = txValid & atHead_q;
    assign pkt_cnt_o  = pktCnt_q;
    assign overflow_o = overflow_q;

    // Next-state logic for pointers, occupancy, head tracking, packet count
    // and the sticky overflow flag. Pointers are exactly log2(depth) bits
    // wide so they wrap on their own. The head flag remembers whether the
    // flit just consumed closed a packet, which makes the next flit a head.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        occupancy_d = occupancy_q;
        pktCnt_d    = pktCnt_q;
        atHead_d    = atHead_q;
        overflow_d  = overflow_q;

        if (push) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end

        if (pop) begin
            rdPtr_d  = rdPtr_q + 1'b1;
            atHead_d = oldestEntry[FLIT_SIZE];
        end

        case ({push, pop})
            2'b10:   occupancy_d = occupancy_q + 1'b1;
            2'b01:   occupancy_d = occupancy_q - 1'b1;
            default: occupancy_d = occupancy_q;
        endcase

        case ({pushEop, popEop})
            2'b10:   pktCnt_d = pktCnt_q + 1'b1;
            2'b01:   pktCnt_d = pktCnt_q - 1'b1;
            default: pktCnt_d = pktCnt_q;
        endcase

        if (rx_i && !credit_o) begin
            overflow_d = 1'b1;
        end
    end

    // Control state register. Reset is asynchronous so a partial packet is
    // thrown away immediately, and the buffer restarts expecting a head flit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            occupancy_q <= '0;
            pktCnt_q    <= '0;
            atHead_q    <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            occupancy_q <= occupancy_d;
            pktCnt_q    <= pktCnt_d;
            atHead_q    <= atHead_d;
            overflow_q  <= overflow_d;
        end
    end

    // Flit storage has no reset; only accepted flits are ever written, and
    // nothing is read out unless the occupancy says the entry is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wrPtr_q] <= {eop_i, data_i};
        end
    end

    // Every stored EOP flit was counted when it arrived, so popping one with
    // the counter already at zero means the bookkeeping has gone wrong.
    pktCntNoUnderflow : assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(popEop && !pushEop && (pktCnt_q == '0))
    );

endmodule

// File: tb/tb_phivers_input_buffer.sv
// ---------------------------------------------------------------------------
// Testbench for phivers_input_buffer. A queue-based reference model tracks
// the flits held, the sticky overflow flag and whether the next flit starts a
// packet. Each scenario task drives stimulus and compares DUT outputs against
// the model or against fixed expected values.
// ---------------------------------------------------------------------------
module tb_phivers_input_buffer;

    localparam int BS = 8;
    localparam int FS = 32;
    localparam int CW = $clog2(BS + 1);

    logic          clk;
    logic          rst;
    logic          rx;
    logic          eopIn;
    logic [FS-1:0] dataIn;
    logic          ack;
    logic          creditOut;
    logic          tx;
    logic          eopOut;
    logic [FS-1:0] dataOut;
    logic          head;
    logic [CW-1:0] pktCnt;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    logic [FS:0] modelQ [$];
    bit          mOverflow;
    bit          mAtHead;

    phivers_input_buffer #(
        .BUFFER_SIZE (BS),
        .FLIT_SIZE   (FS)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx_i       (rx),
        .credit_o   (creditOut),
        .eop_i      (eopIn),
        .data_i     (dataIn),
        .tx_o       (tx),
        .ack_i      (ack),
        .eop_o      (eopOut),
        .data_o     (dataOut),
        .head_o     (head),
        .pkt_cnt_o  (pktCnt),
        .overflow_o (overflow)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model views derived from the queue contents.
    function automatic bit mTx();
        return modelQ.size() != 0;
    endfunction

    function automatic bit mCredit();
        return modelQ.size() != BS;
    endfunction

    function automatic logic [FS-1:0] mData();
        logic [FS:0] e;
        if (modelQ.size() == 0) return '0;
        e = modelQ[0];
        return e[FS-1:0];
    endfunction

    function automatic bit mEop();
        logic [FS:0] e;
        if (modelQ.size() == 0) return 1'b0;
        e = modelQ[0];
        return e[FS];
    endfunction

    function automatic bit mHead();
        return mTx() && mAtHead;
    endfunction

    function automatic int mPkt();
        int n = 0;
        foreach (modelQ[i]) begin
            logic [FS:0] e;
            e = modelQ[i];
            if (e[FS]) n++;
        end
        return n;
    endfunction

    // Put the model back into its power-on state.
    task automatic modelReset();
        modelQ.delete();
        mOverflow = 1'b0;
        mAtHead   = 1'b1;
    endtask

    // Set link/switch inputs for the coming clock edge.
    task automatic drive(input bit r, input bit e, input logic [FS-1:0] d, input bit a);
        rx     = r;
        eopIn  = e;
        dataIn = d;
        ack    = a;
    endtask

    // Advance one clock and apply the same transaction to the model, then
    // settle on the falling edge where outputs are sampled.
    task automatic step();
        bit doPush;
        bit doPop;
        logic [FS:0] e;
        @(posedge clk);
        doPush = rx && (modelQ.size() < BS);
        doPop  = ack && (modelQ.size() > 0);
        if (rx && !doPush) mOverflow = 1'b1;
        if (doPop) begin
            e = modelQ.pop_front();
            mAtHead = e[FS];
        end
        if (doPush) modelQ.push_back({eopIn, dataIn});
        @(negedge clk);
    endtask

    // Synchronised reset pulse used between scenarios.
    task automatic doReset();
        drive(0, 0, '0, 0);
        rst = 1'b1;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reset is raised between clock edges; outputs must respond at once.
    task automatic test_reset();
        drive(0, 0, '0, 0);
        #3 rst = 1'b1;
        #1;
        checks++; if (creditOut !== 1'b1) begin errors++; $display("[TB] FAIL reset_credit: got %b expected 1", creditOut); end
        checks++; if (tx !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx: got %b expected 0", tx); end
        checks++; if (head !== 1'b0) begin errors++; $display("[TB] FAIL reset_head: got %b expected 0", head); end
        checks++; if (eopOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_eop: got %b expected 0", eopOut); end
        checks++; if (dataOut !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", dataOut); end
        checks++; if (pktCnt !== '0) begin errors++; $display("[TB] FAIL reset_pkt: got %0d expected 0", pktCnt); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Three-flit packet with no acknowledge: first flit falls through.
    task automatic test_basic();
        drive(1, 0, 32'h11, 0);
        step();
        checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL basic_tx: got %b expected 1", tx); end
        checks++; if (dataOut !== 32'h11) begin errors++; $display("[TB] FAIL basic_data_first: got %h expected 11", dataOut); end
        checks++; if (head !== 1'b1) begin errors++; $display("[TB] FAIL basic_head_first: got %b expected 1", head); end
        drive(1, 0, 32'h22, 0);
        step();
        drive(1, 1, 32'h33, 0);
        step();
        drive(0, 0, '0, 0);
        checks++; if (dataOut !== 32'h11) begin errors++; $display("[TB] FAIL basic_data: got %h expected 11", dataOut); end
        checks++; if (head !== 1'b1) begin errors++; $display("[TB] FAIL basic_head: got %b expected 1", head); end
        checks++; if (pktCnt !== CW'(1)) begin errors++; $display("[TB] FAIL basic_pkt: got %0d expected 1", pktCnt); end
        checks++; if (creditOut !== 1'b1) begin errors++; $display("[TB] FAIL basic_credit: got %b expected 1", creditOut); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (dataOut !== mData()) begin errors++; $display("[TB] FAIL basic_drain_data: got %h expected %h", dataOut, mData()); end
            checks++; if (head !== mHead()) begin errors++; $display("[TB] FAIL basic_drain_head: got %b expected %b", head, mHead()); end
            drive(0, 0, '0, 1);
            step();
        end
        drive(0, 0, '0, 0);
        checks++; if (tx !== 1'b0) begin errors++; $display("[TB] FAIL basic_empty: got %b expected 0", tx); end
    endtask

    // Fill to the brim, attempt one more, then drain in order.
    task automatic test_fill();
        doReset();
        for (int i = 0; i < BS; i++) begin
            drive(1, 0, $urandom(), 0);
            step();
        end
        checks++; if (creditOut !== 1'b0) begin errors++; $display("[TB] FAIL fill_credit_full: got %b expected 0", creditOut); end
        drive(1, 1, $urandom(), 0);
        step();
        drive(0, 0, '0, 0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL fill_overflow: got %b expected 1", overflow); end
        checks++; if (pktCnt !== '0) begin errors++; $display("[TB] FAIL fill_dropped_eop: got %0d expected 0", pktCnt); end
        checks++; if (creditOut !== 1'b0) begin errors++; $display("[TB] FAIL fill_credit_after_drop: got %b expected 0", creditOut); end
        for (int i = 0; i < BS; i++) begin
            checks++; if (dataOut !== mData()) begin errors++; $display("[TB] FAIL fill_order[%0d]: got %h expected %h", i, dataOut, mData()); end
            drive(0, 0, '0, 1);
            step();
            if (i == 0) begin
                checks++; if (creditOut !== 1'b1) begin errors++; $display("[TB] FAIL fill_credit_return: got %b expected 1", creditOut); end
            end
        end
        drive(0, 0, '0, 0);
        checks++; if (tx !== 1'b0) begin errors++; $display("[TB] FAIL fill_empty: got %b expected 0", tx); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL fill_overflow_sticky: got %b expected 1", overflow); end
    endtask

    // Full buffer sees a push attempt and an acknowledge in the same cycle.
    task automatic test_full_push_pop();
        doReset();
        for (int i = 0; i < BS; i++) begin
            drive(1, $urandom_range(0, 1), $urandom(), 0);
            step();
        end
        drive(1, 1, $urandom(), 1);
        step();
        drive(0, 0, '0, 0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL fullpp_overflow: got %b expected 1", overflow); end
        checks++; if (creditOut !== 1'b1) begin errors++; $display("[TB] FAIL fullpp_credit: got %b expected 1", creditOut); end
        checks++; if (pktCnt !== CW'(mPkt())) begin errors++; $display("[TB] FAIL fullpp_pkt: got %0d expected %0d", pktCnt, mPkt()); end
        for (int i = 0; i < BS - 1; i++) begin
            checks++; if (dataOut !== mData()) begin errors++; $display("[TB] FAIL fullpp_order[%0d]: got %h expected %h", i, dataOut, mData()); end
            drive(0, 0, '0, 1);
            step();
        end
        drive(0, 0, '0, 0);
        checks++; if (tx !== 1'b0) begin errors++; $display("[TB] FAIL fullpp_count: got tx %b expected 0 after 7 pops", tx); end
    endtask

    // Continuous streaming of four-flit packets with push and pop every cycle.
    task automatic test_stream();
        int popped = 0;
        doReset();
        for (int i = 0; i < 24; i++) begin
            drive(i < 20, (i % 4) == 3, $urandom(), 1);
            if (tx) begin
                checks++; if (dataOut !== mData()) begin errors++; $display("[TB] FAIL stream_data[%0d]: got %h expected %h", popped, dataOut, mData()); end
                checks++; if (head !== ((popped % 4) == 0)) begin errors++; $display("[TB] FAIL stream_head[%0d]: got %b expected %b", popped, head, (popped % 4) == 0); end
                popped++;
            end
            checks++; if (pktCnt > CW'(2) || pktCnt !== CW'(mPkt())) begin errors++; $display("[TB] FAIL stream_pkt: got %0d expected %0d", pktCnt, mPkt()); end
            checks++; if (creditOut !== 1'b1) begin errors++; $display("[TB] FAIL stream_credit: got %b expected 1", creditOut); end
            step();
        end
        drive(0, 0, '0, 0);
        checks++; if (popped !== 20) begin errors++; $display("[TB] FAIL stream_count: got %0d expected 20", popped); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL stream_overflow: got %b expected 0", overflow); end
    endtask

    // Back-to-back single-flit packets: every flit is a head.
    task automatic test_single_flit();
        logic [FS-1:0] vals [3];
        vals[0] = 32'hA;
        vals[1] = 32'hB;
        vals[2] = 32'hC;
        doReset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, vals[i], 0);
            step();
        end
        drive(0, 0, '0, 0);
        checks++; if (pktCnt !== CW'(3)) begin errors++; $display("[TB] FAIL single_pkt_full: got %0d expected 3", pktCnt); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (head !== 1'b1) begin errors++; $display("[TB] FAIL single_head[%0d]: got %b expected 1", i, head); end
            checks++; if (dataOut !== vals[i]) begin errors++; $display("[TB] FAIL single_data[%0d]: got %h expected %h", i, dataOut, vals[i]); end
            drive(0, 0, '0, 1);
            step();
            checks++; if (pktCnt !== CW'(2 - i)) begin errors++; $display("[TB] FAIL single_pkt[%0d]: got %0d expected %0d", i, pktCnt, 2 - i); end
        end
        drive(0, 0, '0, 0);
    endtask

    // Asynchronous reset in the middle of a packet.
    task automatic test_async_reset();
        doReset();
        for (int i = 0; i < 5; i++) begin
            drive(1, i == 1, $urandom(), 0);
            step();
        end
        checks++; if (pktCnt !== CW'(1)) begin errors++; $display("[TB] FAIL async_pre_pkt: got %0d expected 1", pktCnt); end
        drive(1, 0, $urandom(), 1);
        #2 rst = 1'b1;
        #1;
        checks++; if (creditOut !== 1'b1) begin errors++; $display("[TB] FAIL async_credit: got %b expected 1", creditOut); end
        checks++; if (tx !== 1'b0) begin errors++; $display("[TB] FAIL async_tx: got %b expected 0", tx); end
        checks++; if (head !== 1'b0) begin errors++; $display("[TB] FAIL async_head: got %b expected 0", head); end
        checks++; if (dataOut !== '0 || eopOut !== 1'b0) begin errors++; $display("[TB] FAIL async_data: got %h/%b expected 0/0", dataOut, eopOut); end
        checks++; if (pktCnt !== '0) begin errors++; $display("[TB] FAIL async_pkt: got %0d expected 0", pktCnt); end
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 32'h5A, 0);
        step();
        drive(0, 0, '0, 0);
        checks++; if (head !== 1'b1) begin errors++; $display("[TB] FAIL async_next_head: got %b expected 1", head); end
        checks++; if (dataOut !== 32'h5A) begin errors++; $display("[TB] FAIL async_next_data: got %h expected 5a", dataOut); end
    endtask

    // Random traffic with phases biased toward filling and draining.
    task automatic test_random();
        doReset();
        for (int i = 0; i < 400; i++) begin
            bit fillPhase;
            fillPhase = ((i / 50) % 2) == 0;
            drive(fillPhase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0),
                  $urandom_range(0, 2) == 0, $urandom(),
                  fillPhase ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0));
            step();
            checks++;
            if (tx !== mTx() || creditOut !== mCredit() || dataOut !== mData() || eopOut !== mEop() ||
                head !== mHead() || pktCnt !== CW'(mPkt()) || overflow !== mOverflow) begin
                errors++;
                $display("[TB] FAIL random[%0d]: got tx=%b cr=%b d=%h e=%b h=%b p=%0d o=%b expected tx=%b cr=%b d=%h e=%b h=%b p=%0d o=%b",
                         i, tx, creditOut, dataOut, eopOut, head, pktCnt, overflow,
                         mTx(), mCredit(), mData(), mEop(), mHead(), mPkt(), mOverflow);
            end
        end
        drive(0, 0, '0, 0);
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, '0, 0);
        modelReset();
        test_reset();
        test_basic();
        test_fill();
        test_full_push_pop();
        test_stream();
        test_single_flit();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/phivers_input_buffer.md
Name: phivers_input_buffer

Overview:
Router input-port buffer that consumes the flit stream arriving over an inter-router link and returns a credit signal to it.
- Stores flits in a BUFFER_SIZE-deep circular FIFO.
- Presents the oldest flit to the local switch / routing stage.
- Tracks packet boundaries using EOP.
- Exposes a head-flit indication and a count of complete packets held.

Parameters:
BUFFER_SIZE, 8, FIFO depth in flits; power of two, at least 2
FLIT_SIZE, 32, flit data width in bits
CNT_W, $clog2(BUFFER_SIZE+1), width of the packet counter (derived, not overridden)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous reset, active-high
rx_i  input  1  flit valid from link
credit_o  output  1  buffer has space; drives the link's credit return
eop_i  input  1  flit on data_i is the last of its packet
data_i  input  FLIT_SIZE  incoming flit
tx_o  output  1  buffer non-empty; oldest flit valid on data_o
ack_i  input  1  switch consumes the oldest flit this cycle
eop_o  output  1  EOP bit of the oldest flit
data_o  output  FLIT_SIZE  oldest flit
head_o  output  1  oldest flit is the first flit of a packet
pkt_cnt_o  output  CNT_W  number of complete packets (EOP stored) in buffer
overflow_o  output  1  sticky: a flit arrived while credit_o was low

Behaviour:
- Reset (asynchronous, immediate, also mid-packet):
  - wr_ptr, rd_ptr and occupancy go to 0; at_head goes to 1; pkt_cnt goes to 0; overflow goes to 0.
  - Outputs during/after reset: credit_o=1, tx_o=0, head_o=0, eop_o=0, data_o=0, pkt_cnt_o=0, overflow_o=0.
  - Memory contents are not reset.
  - Any partial packet is discarded.
- Storage: BUFFER_SIZE entries of {eop, data}. Occupancy counter is 0..BUFFER_SIZE. Pointers are $clog2(BUFFER_SIZE) bits and wrap naturally from BUFFER_SIZE-1 to 0.
- credit_o = (occupancy != BUFFER_SIZE). Combinational from registered state only; no input feeds it combinationally.
- Push: occurs when rx_i && credit_o.
  - Writes {eop_i, data_i} at wr_ptr.
  - wr_ptr+1, occupancy+1.
- rx_i while credit_o=0:
  - The flit is dropped.
  - Memory, pointers and counters are unchanged.
  - overflow_o is set and stays set until reset.
- Output is first-word-fall-through:
  - tx_o = (occupancy != 0).
  - data_o/eop_o = mem[rd_ptr] when tx_o=1, otherwise forced to 0.
- Pop: occurs when tx_o && ack_i.
  - rd_ptr+1, occupancy-1.
  - ack_i while tx_o=0 is ignored.
- Latency: a flit pushed in cycle N is visible on tx_o/data_o in cycle N+1 at the earliest.
- Simultaneous push and pop:
  - Occupancy is unchanged; both pointers advance.
  - When full, credit_o=0, so no push is accepted even if a pop occurs in the same cycle. Credit is pre-declared; the freed slot is advertised the following cycle.
  - When empty, no pop is possible, so a same-cycle push only increments occupancy.
- Head tracking:
  - at_head register: on each pop, at_head <= eop_o of the popped flit.
  - head_o = tx_o && at_head.
- Packet counter:
  - +1 on a push with eop_i=1.
  - -1 on a pop with eop_o=1.
  - Both in the same cycle leaves it unchanged.
  - Saturation cannot occur because pkt_cnt never exceeds occupancy. A decrement below 0 is an assertion failure in simulation.
- Single-flit packets (eop on the head flit) are legal. head_o stays 1 for the following flit.

Test Plan:
1. Reset, then push 3 flits (0x11, 0x22, 0x33 with eop) with ack_i=0 -> tx_o=1 from cycle after first push; data_o=0x11; head_o=1; pkt_cnt_o=1; credit_o=1.
2. Fill BUFFER_SIZE=8 flits with no ack -> credit_o=0 after the 8th push. A 9th rx_i is dropped: overflow_o=1, occupancy stays 8. Pops then return flits 1..8 in order; credit_o returns to 1 the cycle after the first pop.
3. Continuous streaming, rx_i and ack_i high every cycle for 20 flits, packets of length 4 -> no drops; in-order data; pointers wrap twice; head_o=1 exactly on flits 0,4,8,...; pkt_cnt_o never exceeds 2.
4. Full buffer with push attempt and ack_i in the same cycle -> pop occurs, push is dropped with overflow_o=1, occupancy becomes 7.
5. Back-to-back single-flit packets 0xA, 0xB, 0xC (all eop=1) -> head_o=1 for every popped flit; pkt_cnt_o goes 3,2,1,0.
6. Assert rst_i asynchronously mid-packet (occupancy 5, pkt_cnt_o 1) -> all outputs return to reset values without waiting for a clock edge. The next pushed flit appears with head_o=1.
